wshb_mire_writer: RTL and testbench

WSHB_MIRE_WRITER -- requirements
Module: wshb_mire_writer

---
 rtl/wshb_mire_writer_pkg.sv | 23 ++
 rtl/mire_pixel_gen.sv | 59 +++++
 rtl/wshb_mire_writer.sv | 95 +++++++++
 tb/tb_wshb_mire_writer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wshb_mire_writer_pkg.sv
// Shared definitions for the Wishbone frame-buffer masters (mire writer, VGA reader).
// Holds the master FSM state encoding, the cycle-type constants and the grid pattern rule.
package wshb_mire_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } wr_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] SEL_FULL    = 2'b11;

  // A grid line is drawn on every 16th column and every 16th row.
  function automatic logic [15:0] grid_pixel(input logic [3:0] x_low, input logic [3:0] y_low);
    return ((x_low == 4'd0) || (y_low == 4'd0)) ? 16'hFFFF : 16'h0000;
  endfunction

endpackage

// File: rtl/mire_pixel_gen.sv
// Raster position counters for the test-pattern writer, plus the pixel colour and
// byte address of the current position. The position only moves when `advance` is high.
module mire_pixel_gen
  import wshb_mire_writer_pkg::*;
#(
  parameter int          HDISP    = 640,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] adr,
  output logic [15:0] dat,
  output logic        last_pixel
);

  // At least 4 bits so the grid test on x[3:0]/y[3:0] is always well formed.
  localparam int XW = ($clog2(HDISP) < 4) ? 4 : $clog2(HDISP);
  localparam int YW = ($clog2(VDISP) < 4) ? 4 : $clog2(VDISP);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;
  logic [31:0]   pix_idx;

  assign x_last = (x_q == XW'(HDISP - 1));
  assign y_last = (y_q == YW'(VDISP - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign pix_idx    = 32'(y_q) * 32'(HDISP) + 32'(x_q);
  assign adr        = BASE_ADR + (pix_idx << 1);
  assign dat        = grid_pixel(x_q[3:0], y_q[3:0]);
  assign last_pixel = x_last && y_last;

endmodule

// File: rtl/wshb_mire_writer.sv
// Wishbone master that fills the frame buffer with a grid test pattern using fixed-length
// incrementing bursts, releasing the bus for one cycle between bursts.
module wshb_mire_writer
  import wshb_mire_writer_pkg::*;
#(
  parameter int          HDISP    = 640,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 16,
  parameter logic [31:0] BASE_ADR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] adr,
  output logic [15:0] dat_ms,
  output logic [1:0]  sel,
  output logic        we,
  output logic        cyc,
  output logic        stb,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  output logic        frame_done
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

  wr_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              en_q, en_d;
  logic              beat_done;
  logic              last_beat;
  logic              last_pixel;

  // An ack only counts while we are actually strobing.
  assign beat_done = (state_q == ST_BURST) && ack;
  assign last_beat = (beat_q == BEAT_W'(BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      en_q    <= en_d;
    end
  end

  // en is registered so IDLE leaves one cycle after en is seen high.
  always_comb begin
    state_d = state_q;
    en_d    = en;
    beat_d  = beat_q;
    if (beat_done) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end
    case (state_q)
      ST_IDLE:  if (en_q) state_d = ST_BURST;
      ST_BURST: if (beat_done && last_beat) state_d = ST_GAP;
      ST_GAP:   state_d = en ? ST_BURST : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc = 1'b0;
    stb = 1'b0;
    cti = CTI_CLASSIC;
    if (state_q == ST_BURST) begin
      cyc = 1'b1;
      stb = 1'b1;
      cti = last_beat ? CTI_END : CTI_INCR;
    end
    we         = cyc;
    sel        = SEL_FULL;
    bte        = BTE_LINEAR;
    frame_done = beat_done && last_pixel;
  end

  mire_pixel_gen #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .BASE_ADR (BASE_ADR)
  ) u_pixel_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (beat_done),
    .adr        (adr),
    .dat        (dat_ms),
    .last_pixel (last_pixel)
  );

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Directed bench for wshb_mire_writer: a default-sized instance for bus behaviour and a
// small-frame instance so a whole frame (and its wrap) fits in a short run.
module tb_wshb_mire_writer;

  logic        clk = 1'b0;
  logic        rst_n, en, ack;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [1:0]  sel, bte;
  logic        we, cyc, stb, frame_done;
  logic [2:0]  cti;

  logic        s_rst_n, s_en, s_ack;
  logic [31:0] s_adr;
  logic [15:0] s_dat;
  logic [1:0]  s_sel, s_bte;
  logic        s_we, s_cyc, s_stb, s_frame_done;
  logic [2:0]  s_cti;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  wshb_mire_writer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adr(adr), .dat_ms(dat_ms), .sel(sel), .we(we),
    .cyc(cyc), .stb(stb), .cti(cti), .bte(bte), .ack(ack), .frame_done(frame_done)
  );

  // 32x4 frame, 8-beat bursts: 16 bursts of 9 cycles per frame, last pixel at 0x100+254.
  wshb_mire_writer #(.HDISP(32), .VDISP(4), .BURST(8), .BASE_ADR(32'h100)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .adr(s_adr), .dat_ms(s_dat), .sel(s_sel), .we(s_we),
    .cyc(s_cyc), .stb(s_stb), .cti(s_cti), .bte(s_bte), .ack(s_ack), .frame_done(s_frame_done)
  );

  function automatic logic [31:0] exp_adr(input int x, input int y);
    return 32'(2 * (y * 640 + x));
  endfunction

  function automatic logic [15:0] exp_dat(input int x, input int y);
    return ((x % 16 == 0) || (y % 16 == 0)) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic wait_adr(input logic [31:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cyc === 1'b1 && adr === target) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; ack = 1'b0;
    s_rst_n = 1'b0; s_en = 1'b0; s_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0)
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b want 000", cyc, stb, we); else passes++;
    checks++; if (cti !== 3'b000) $display("FAIL reset_cti: got %b want 000", cti); else passes++;
    checks++; if (adr !== 32'd0) $display("FAIL reset_adr: got %0d want 0", adr); else passes++;
    checks++; if (dat_ms !== 16'hFFFF) $display("FAIL reset_dat: got %h want ffff", dat_ms); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passes++;
    checks++; if (sel !== 2'b11 || bte !== 2'b00)
      $display("FAIL reset_sel_bte: sel=%b bte=%b want 11 00", sel, bte); else passes++;
  endtask

  task automatic test_first_burst;
    en = 1'b1; ack = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (stb !== 1'b0) $display("FAIL latency_cycle1: stb=%b want 0", stb); else passes++;
    @(negedge clk);
    checks++; if (stb !== 1'b1) $display("FAIL latency_cycle2: stb=%b want 1", stb); else passes++;
    for (int b = 0; b < 16; b++) begin
      checks++; if (adr !== exp_adr(b, 0) || dat_ms !== 16'hFFFF)
        $display("FAIL first_burst_beat%0d: adr=%0d dat=%h want adr=%0d dat=ffff", b, adr, dat_ms, exp_adr(b, 0));
      else passes++;
      checks++; if (cti !== ((b == 15) ? 3'b111 : 3'b010) || we !== 1'b1 || cyc !== 1'b1)
        $display("FAIL first_burst_cti%0d: cti=%b we=%b cyc=%b", b, cti, we, cyc); else passes++;
      @(negedge clk);
    end
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) $display("FAIL first_gap: cyc=%b stb=%b want 0 0", cyc, stb); else passes++;
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || adr !== 32'd32 || dat_ms !== 16'hFFFF)
      $display("FAIL second_burst_start: cyc=%b adr=%0d dat=%h want 1 32 ffff", cyc, adr, dat_ms); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL early_frame_done: got %b want 0", frame_done); else passes++;
  endtask

  task automatic test_second_line;
    bit ok;
    int x = 0;
    int guard = 0;
    wait_adr(32'd1280, 2000, ok);
    checks++; if (!ok) $display("FAIL line1_reach: adr=%0d want 1280", adr); else passes++;
    while (x < 48 && guard < 100) begin
      if (cyc === 1'b1) begin
        checks++; if (adr !== exp_adr(x, 1) || dat_ms !== exp_dat(x, 1))
          $display("FAIL line1_x%0d: adr=%0d dat=%h want adr=%0d dat=%h", x, adr, dat_ms, exp_adr(x, 1), exp_dat(x, 1));
        else passes++;
        x++;
      end
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_ack_stall;
    bit ok;
    wait_adr(exp_adr(52, 1), 100, ok);
    checks++; if (!ok) $display("FAIL stall_reach: adr=%0d want %0d", adr, exp_adr(52, 1)); else passes++;
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (adr !== exp_adr(52, 1) || dat_ms !== 16'h0000 || cti !== 3'b010 || stb !== 1'b1)
        $display("FAIL stall_hold%0d: adr=%0d dat=%h cti=%b stb=%b want %0d 0000 010 1", i, adr, dat_ms, cti, stb, exp_adr(52, 1));
      else passes++;
    end
    ack = 1'b1;
    @(negedge clk);
    checks++; if (adr !== exp_adr(53, 1)) $display("FAIL stall_resume: adr=%0d want %0d", adr, exp_adr(53, 1)); else passes++;
  endtask

  task automatic test_gap;
    bit ok;
    wait_adr(exp_adr(63, 1), 100, ok);
    checks++; if (!ok || cti !== 3'b111) $display("FAIL gap_last_cti: cti=%b want 111", cti); else passes++;
    @(negedge clk);
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0)
      $display("FAIL gap_idle_bus: cyc=%b stb=%b we=%b want 000", cyc, stb, we); else passes++;
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || adr !== exp_adr(64, 1) || cti !== 3'b010)
      $display("FAIL gap_next_burst: cyc=%b adr=%0d cti=%b want 1 %0d 010", cyc, adr, cti, exp_adr(64, 1)); else passes++;
  endtask

  task automatic test_en_low_mid_burst;
    bit ok;
    wait_adr(exp_adr(68, 1), 100, ok);
    checks++; if (!ok) $display("FAIL en_low_reach: adr=%0d want %0d", adr, exp_adr(68, 1)); else passes++;
    en = 1'b0;
    for (int x = 68; x < 80; x++) begin
      checks++; if (cyc !== 1'b1 || adr !== exp_adr(x, 1))
        $display("FAIL en_low_beat_x%0d: cyc=%b adr=%0d want 1 %0d", x, cyc, adr, exp_adr(x, 1)); else passes++;
      @(negedge clk);
    end
    checks++; if (cyc !== 1'b0) $display("FAIL en_low_gap: cyc=%b want 0", cyc); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (cyc !== 1'b0 || adr !== exp_adr(80, 1))
      $display("FAIL en_low_idle: cyc=%b adr=%0d want 0 %0d", cyc, adr, exp_adr(80, 1)); else passes++;
    en = 1'b1;
    @(negedge clk);
    checks++; if (cyc !== 1'b0) $display("FAIL en_resume_wait: cyc=%b want 0", cyc); else passes++;
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || adr !== exp_adr(80, 1))
      $display("FAIL en_resume: cyc=%b adr=%0d want 1 %0d", cyc, adr, exp_adr(80, 1)); else passes++;
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    wait_adr(exp_adr(87, 1), 100, ok);
    checks++; if (!ok) $display("FAIL rst_mid_reach: adr=%0d want %0d", adr, exp_adr(87, 1)); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || adr !== 32'd0 || dat_ms !== 16'hFFFF)
      $display("FAIL rst_mid_async: cyc=%b stb=%b adr=%0d dat=%h want 0 0 0 ffff", cyc, stb, adr, dat_ms); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (stb !== 1'b0) $display("FAIL rst_mid_latency1: stb=%b want 0", stb); else passes++;
    @(negedge clk);
    checks++; if (stb !== 1'b1 || adr !== 32'd0)
      $display("FAIL rst_mid_restart: stb=%b adr=%0d want 1 0", stb, adr); else passes++;
  endtask

  task automatic test_frame_done;
    bit found = 1'b0;
    int pulses = 0;
    s_en = 1'b1; s_ack = 1'b1; s_rst_n = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (s_frame_done === 1'b1) found = 1'b1;
    end
    checks++; if (!found || s_adr !== 32'h1FE || s_cti !== 3'b111)
      $display("FAIL frame_done_pixel: found=%b adr=%h cti=%b want 1 1fe 111", found, s_adr, s_cti); else passes++;
    @(negedge clk);
    checks++; if (s_frame_done !== 1'b0 || s_cyc !== 1'b0)
      $display("FAIL frame_done_after: frame_done=%b cyc=%b want 0 0", s_frame_done, s_cyc); else passes++;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h100)
      $display("FAIL frame_wrap: cyc=%b adr=%h want 1 100", s_cyc, s_adr); else passes++;
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      if (s_frame_done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) $display("FAIL frame_done_count: got %0d want 1", pulses); else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_burst();
    test_second_line();
    test_ack_stall();
    test_gap();
    test_en_low_mid_burst();
    test_reset_mid_burst();
    test_frame_done();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
